// File: rtl/build_packet_if.sv
// 32-bit AXI-Stream bus, used for both the payload input and the frame output
// of build_packet.
interface build_packet_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/build_packet.sv
// Prepends a 42-byte Ethernet II + IPv4 + UDP header to a UDP payload stream and
// emits the frame on a 32-bit AXI-Stream, realigning the payload by two bytes.
module build_packet #(
  parameter logic [7:0] IP_TTL = 8'h40,
  parameter bit         IP_DF  = 1'b1
) (
  input  logic           axis_clk,
  input  logic           axis_reset,
  input  logic [47:0]    dest_addr,
  input  logic [47:0]    src_addr,
  input  logic [31:0]    ip_src_addr,
  input  logic [31:0]    ip_dest_addr,
  input  logic [15:0]    udp_src_port,
  input  logic [15:0]    udp_dest_port,
  input  logic [15:0]    payload_len,
  input  logic           hdr_valid,
  output logic           hdr_ready,
  build_packet_if.slave  s_axis,
  build_packet_if.master m_axis,
  output logic           len_err
);

  typedef enum logic [2:0] {IDLE, CSUM, HDR, ZERO, PAY, FLUSH} state_t;

  localparam logic [15:0] IP_FLAGS = IP_DF ? 16'h4000 : 16'h0000;

  state_t      state, state_nxt;
  logic [3:0]  word_q, word_nxt;
  logic [15:0] carry_q, carry_nxt;
  logic [1:0]  fkeep_q, fkeep_nxt;
  logic [15:0] cnt_q, cnt_nxt;
  logic [15:0] csum_q;
  logic        hdr_ready_q, len_err_q, err_nxt;

  logic [47:0] dest_q, src_q;
  logic [31:0] ip_src_q, ip_dst_q;
  logic [15:0] sport_q, dport_q, plen_q;

  logic        m_valid_q, m_last_q;
  logic [3:0]  m_keep_q;
  logic [31:0] m_data_q;

  logic        out_free, s_ready, ld, ld_last;
  logic [3:0]  ld_keep;
  logic [31:0] ld_data, hdr_word;
  logic [15:0] ip_len, udp_len, beat_bytes, csum_calc;
  logic [19:0] csum_acc;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  assign ip_len  = plen_q + 16'd28;
  assign udp_len = plen_q + 16'd8;

  // One's-complement sum of the ten IP header words, checksum word taken as 0.
  assign csum_acc = 20'(16'h4500) + 20'(ip_len) + 20'(IP_FLAGS) + 20'({IP_TTL, 8'h11})
                  + 20'(ip_src_q[31:16]) + 20'(ip_src_q[15:0])
                  + 20'(ip_dst_q[31:16]) + 20'(ip_dst_q[15:0]);
  assign csum_f1   = 17'(csum_acc[15:0]) + 17'(csum_acc[19:16]);
  assign csum_f2   = csum_f1[15:0] + 16'(csum_f1[16]);
  assign csum_calc = ~csum_f2;

  // Header words in wire order (MSB = first byte), swapped onto lanes later.
  always_comb begin
    case (word_q)
      4'd0:    hdr_word = dest_q[47:16];
      4'd1:    hdr_word = {dest_q[15:0], src_q[47:32]};
      4'd2:    hdr_word = src_q[31:0];
      4'd3:    hdr_word = 32'h0800_4500;
      4'd4:    hdr_word = {ip_len, 16'h0000};
      4'd5:    hdr_word = {IP_FLAGS, IP_TTL, 8'h11};
      4'd6:    hdr_word = {csum_q, ip_src_q[31:16]};
      4'd7:    hdr_word = {ip_src_q[15:0], ip_dst_q[31:16]};
      4'd8:    hdr_word = {ip_dst_q[15:0], sport_q};
      4'd9:    hdr_word = {dport_q, udp_len};
      default: hdr_word = '0;
    endcase
  end

  assign out_free   = !m_valid_q || m_axis.tready;
  assign beat_bytes = 16'(s_axis.tkeep[0]) + 16'(s_axis.tkeep[1])
                    + 16'(s_axis.tkeep[2]) + 16'(s_axis.tkeep[3]);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    word_nxt  = word_q;
    carry_nxt = carry_q;
    fkeep_nxt = fkeep_q;
    cnt_nxt   = cnt_q;
    err_nxt   = 1'b0;
    s_ready   = 1'b0;
    ld        = 1'b0;
    ld_data   = '0;
    ld_keep   = '0;
    ld_last   = 1'b0;
    case (state)
      IDLE: if (hdr_valid && hdr_ready_q) state_nxt = CSUM;
      CSUM: begin
        word_nxt  = '0;
        state_nxt = HDR;
      end
      HDR: if (out_free) begin
        ld      = 1'b1;
        ld_data = bswap(hdr_word);
        ld_keep = 4'hF;
        if (word_q == 4'd9) begin
          carry_nxt = 16'h0000;  // bytes 40-41: unused UDP checksum
          cnt_nxt   = '0;
          state_nxt = (plen_q == 16'd0) ? ZERO : PAY;
        end else begin
          word_nxt = word_q + 4'd1;
        end
      end
      ZERO: if (out_free) begin
        ld        = 1'b1;
        ld_data   = {16'h0000, carry_q};
        ld_keep   = 4'h3;
        ld_last   = 1'b1;
        state_nxt = IDLE;
      end
      PAY: begin
        s_ready = out_free;
        if (s_axis.tvalid && out_free) begin
          ld        = 1'b1;
          ld_data   = {s_axis.tdata[15:0], carry_q};
          ld_keep   = 4'hF;
          carry_nxt = s_axis.tdata[31:16];
          cnt_nxt   = cnt_q + beat_bytes;
          if (s_axis.tlast) begin
            err_nxt = (cnt_nxt != plen_q);
            if (s_axis.tkeep[2]) begin
              fkeep_nxt = s_axis.tkeep[3:2];
              state_nxt = FLUSH;
            end else begin
              ld_keep   = {s_axis.tkeep[1:0], 2'b11};
              ld_last   = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      FLUSH: if (out_free) begin
        ld        = 1'b1;
        ld_data   = {16'h0000, carry_q};
        ld_keep   = {2'b00, fkeep_q};
        ld_last   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state       <= IDLE;
      word_q      <= '0;
      carry_q     <= '0;
      fkeep_q     <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      hdr_ready_q <= 1'b0;
      len_err_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_keep_q    <= '0;
      m_data_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values of
      // the previous cycle regardless of statement order.
      state       <= state_nxt;
      word_q      <= word_nxt;
      carry_q     <= carry_nxt;
      fkeep_q     <= fkeep_nxt;
      cnt_q       <= cnt_nxt;
      hdr_ready_q <= (state_nxt == IDLE);
      len_err_q   <= err_nxt;
      if (state == CSUM) csum_q <= csum_calc;
      if (ld) begin
        m_valid_q <= 1'b1;
        m_data_q  <= ld_data;
        m_keep_q  <= ld_keep;
        m_last_q  <= ld_last;
      end else if (m_axis.tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: captured header fields carry no reset; they are only read after a
  // handshake has loaded them.
  always_ff @(posedge axis_clk) begin
    if (state == IDLE && hdr_valid && hdr_ready_q) begin
      dest_q   <= dest_addr;
      src_q    <= src_addr;
      ip_src_q <= ip_src_addr;
      ip_dst_q <= ip_dest_addr;
      sport_q  <= udp_src_port;
      dport_q  <= udp_dest_port;
      plen_q   <= payload_len;
    end
  end

  assign hdr_ready     = hdr_ready_q;
  assign len_err       = len_err_q;
  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tlast  = m_last_q;

endmodule

// File: tb/tb_build_packet.sv
// Self-checking bench for build_packet: a byte-level frame model predicts every
// output beat; randomized payloads, lengths and downstream stalls.
module tb_build_packet;
  localparam logic [7:0] TTL = 8'h40;
  localparam bit         DF  = 1'b1;

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [31:0] ipsrc;
    logic [31:0] ipdst;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] plen;
  } hdr_t;

  logic        axis_clk = 1'b0;
  logic        axis_reset = 1'b1;
  logic [47:0] dest_addr = '0, src_addr = '0;
  logic [31:0] ip_src_addr = '0, ip_dest_addr = '0;
  logic [15:0] udp_src_port = '0, udp_dest_port = '0, payload_len = '0;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready, len_err;

  build_packet_if s_if();
  build_packet_if m_if();

  build_packet #(.IP_TTL(TTL), .IP_DF(DF)) dut (
    .axis_clk(axis_clk), .axis_reset(axis_reset),
    .dest_addr(dest_addr), .src_addr(src_addr),
    .ip_src_addr(ip_src_addr), .ip_dest_addr(ip_dest_addr),
    .udp_src_port(udp_src_port), .udp_dest_port(udp_dest_port),
    .payload_len(payload_len), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .s_axis(s_if), .m_axis(m_if), .len_err(len_err)
  );

  always #5 axis_clk = ~axis_clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected frame bytes and frame lengths, consumed beat by beat.
  logic [7:0]  exp_q[$];
  int          exp_len[$];
  int          pos = 0, frames_done = 0, exp_errs = 0;
  logic [7:0]  pay[0:255];

  logic [7:0]  rx_bytes[0:511];
  logic [31:0] rx_data[0:127];
  logic [3:0]  rx_keep[0:127];
  int          rx_beats = 0;

  int          rdy_mode = 0;  // 0 always ready, 1 random, 2 held low
  bit          sready_seen = 0, prev_stall = 0, prev_len_err = 0;
  int          len_err_pulses = 0, len_err_hi = 0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last;

  always @(posedge axis_clk) begin
    #1;
    m_if.tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom % 2) : 1'b0;
  end

  int          rem, nb;
  logic [31:0] ed, em;
  logic [3:0]  ek;

  always @(negedge axis_clk) begin
    if (axis_reset) begin
      prev_stall   = 0;
      prev_len_err = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_if.tvalid, 1'b1);
        check("stall_data", m_if.tdata, prev_data);
        check("stall_keep", m_if.tkeep, prev_keep);
        check("stall_last", m_if.tlast, prev_last);
      end
      if (s_if.tready) sready_seen = 1;
      if (len_err) begin
        len_err_hi++;
        if (!prev_len_err) len_err_pulses++;
      end
      prev_len_err = len_err;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_len.size() == 0) begin
          check("unexpected_beat", m_if.tvalid, 1'b0);
        end else begin
          rem = exp_len[0] - pos;
          nb  = (rem > 4) ? 4 : rem;
          ek  = 4'((1 << nb) - 1);
          ed  = '0;
          em  = '0;
          for (int i = 0; i < nb; i++) begin
            ed[8*i +: 8] = exp_q.pop_front();
            em[8*i +: 8] = 8'hFF;
          end
          check("beat_keep", m_if.tkeep, ek);
          check("beat_last", m_if.tlast, rem <= 4);
          check("beat_data", m_if.tdata & em, ed);
          if (pos == 0) rx_beats = 0;
          rx_data[rx_beats] = m_if.tdata;
          rx_keep[rx_beats] = m_if.tkeep;
          for (int i = 0; i < nb; i++) rx_bytes[pos + i] = m_if.tdata[8*i +: 8];
          rx_beats++;
          if (rem <= 4) begin
            void'(exp_len.pop_front());
            pos = 0;
            frames_done++;
          end else begin
            pos += 4;
          end
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_keep  = m_if.tkeep;
      prev_last  = m_if.tlast;
    end
  end

  function automatic logic [15:0] model_csum(input hdr_t h);
    bit [31:0] s;
    logic [15:0] il;
    il = h.plen + 16'd28;
    s = 32'h4500 + 32'(il) + (DF ? 32'h4000 : 32'h0) + {16'h0, TTL, 8'h11}
      + 32'(h.ipsrc[31:16]) + 32'(h.ipsrc[15:0]) + 32'(h.ipdst[31:16]) + 32'(h.ipdst[15:0]);
    while (s[31:16] != 0) s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  function automatic hdr_t rand_hdr(input int plen);
    hdr_t h;
    h.dst   = 48'({$urandom(), $urandom()});
    h.src   = 48'({$urandom(), $urandom()});
    h.ipsrc = $urandom();
    h.ipdst = $urandom();
    h.sport = 16'($urandom());
    h.dport = 16'($urandom());
    h.plen  = 16'(plen);
    return h;
  endfunction

  task automatic send_frame(input hdr_t h, input int nsent, input bit gaps);
    logic [7:0]  hb[42];
    logic [15:0] cs, il, ul;
    int target, nbeats, r;
    il = h.plen + 16'd28;
    ul = h.plen + 16'd8;
    cs = model_csum(h);
    for (int i = 0; i < 6; i++) begin
      hb[i]     = 8'(h.dst >> (8 * (5 - i)));
      hb[6 + i] = 8'(h.src >> (8 * (5 - i)));
    end
    hb[12] = 8'h08; hb[13] = 8'h00; hb[14] = 8'h45; hb[15] = 8'h00;
    hb[16] = il[15:8]; hb[17] = il[7:0]; hb[18] = 8'h00; hb[19] = 8'h00;
    hb[20] = DF ? 8'h40 : 8'h00; hb[21] = 8'h00; hb[22] = TTL; hb[23] = 8'h11;
    hb[24] = cs[15:8]; hb[25] = cs[7:0];
    for (int i = 0; i < 4; i++) begin
      hb[26 + i] = 8'(h.ipsrc >> (8 * (3 - i)));
      hb[30 + i] = 8'(h.ipdst >> (8 * (3 - i)));
    end
    hb[34] = h.sport[15:8]; hb[35] = h.sport[7:0];
    hb[36] = h.dport[15:8]; hb[37] = h.dport[7:0];
    hb[38] = ul[15:8]; hb[39] = ul[7:0]; hb[40] = 8'h00; hb[41] = 8'h00;
    for (int i = 0; i < 42; i++) exp_q.push_back(hb[i]);
    for (int i = 0; i < nsent; i++) exp_q.push_back(pay[i]);
    exp_len.push_back(42 + nsent);
    if (nsent != int'(h.plen)) exp_errs++;
    target = frames_done + 1;

    @(posedge axis_clk); #1;
    dest_addr = h.dst; src_addr = h.src; ip_src_addr = h.ipsrc; ip_dest_addr = h.ipdst;
    udp_src_port = h.sport; udp_dest_port = h.dport; payload_len = h.plen;
    hdr_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge axis_clk);
      if (hdr_ready) break;
    end
    if (!hdr_ready) check("hdr_accept", hdr_ready, 1'b1);
    @(posedge axis_clk); #1;
    hdr_valid = 1'b0;

    nbeats = (nsent + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_if.tvalid = 1'b0;
        @(posedge axis_clk); #1;
      end
      r = nsent - 4 * b;
      for (int i = 0; i < 4; i++) s_if.tdata[8*i +: 8] = (i < r) ? pay[4*b + i] : 8'($urandom());
      s_if.tkeep  = (r >= 4) ? 4'hF : 4'((1 << r) - 1);
      s_if.tlast  = (b == nbeats - 1);
      s_if.tvalid = 1'b1;
      for (int c = 0; c < 500; c++) begin
        @(negedge axis_clk);
        if (s_if.tready) break;
      end
      if (!s_if.tready) check("s_tready_wait", s_if.tready, 1'b1);
      @(posedge axis_clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    for (int c = 0; c < 3000 && frames_done < target; c++) @(negedge axis_clk);
    check("frame_done", frames_done, target);
    repeat (2) @(negedge axis_clk);
  endtask

  hdr_t h;
  int   p0;

  initial begin
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;

    // Reset values, then hdr_ready one clock after release.
    #2;
    check("rst_hdr_ready", hdr_ready, 1'b0);
    check("rst_m_tvalid", m_if.tvalid, 1'b0);
    check("rst_m_tlast", m_if.tlast, 1'b0);
    check("rst_m_tkeep", m_if.tkeep, 4'h0);
    check("rst_m_tdata", m_if.tdata, 32'h0);
    check("rst_s_tready", s_if.tready, 1'b0);
    check("rst_len_err", len_err, 1'b0);
    @(negedge axis_clk); axis_reset = 1'b0;
    @(posedge axis_clk); #1;
    check("rel_hdr_ready", hdr_ready, 1'b1);

    // Checksum example.
    h.dst = 48'h000102030405; h.src = 48'h060708090A0B;
    h.ipsrc = 32'hC0A80001; h.ipdst = 32'hC0A800C7;
    h.sport = 16'h1234; h.dport = 16'h5678; h.plen = 16'd87;
    check("model_csum", model_csum(h), 16'hB861);
    for (int i = 0; i < 87; i++) pay[i] = 8'($urandom());
    send_frame(h, 87, 1'b0);
    check("ip_len_bytes", {rx_bytes[16], rx_bytes[17]}, 16'h0073);
    check("csum_bytes", {rx_bytes[24], rx_bytes[25]}, 16'hB861);
    check("udp_len_bytes", {rx_bytes[38], rx_bytes[39]}, 16'h005F);
    check("csum_frame_beats", rx_beats, 33);

    // 5-byte payload: ends with keep 7.
    p0 = len_err_pulses;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44; pay[4] = 8'h55;
    send_frame(rand_hdr(5), 5, 1'b0);
    check("p5_beats", rx_beats, 12);
    check("p5_word10", rx_data[10], 32'h2211_0000);
    check("p5_word11", rx_data[11][23:0], 24'h554433);
    check("p5_keep11", rx_keep[11], 4'h7);
    check("p5_len_err", len_err_pulses, p0);

    // 7-byte payload: needs a flush beat.
    for (int i = 0; i < 7; i++) pay[i] = 8'(8'hA1 + i);
    send_frame(rand_hdr(7), 7, 1'b0);
    check("p7_beats", rx_beats, 13);
    check("p7_keep11", rx_keep[11], 4'hF);
    check("p7_word11", rx_data[11], 32'hA6A5_A4A3);
    check("p7_keep12", rx_keep[12], 4'h1);
    check("p7_word12", rx_data[12][7:0], 8'hA7);

    // Zero-length payload.
    sready_seen = 0;
    send_frame(rand_hdr(0), 0, 1'b0);
    check("p0_beats", rx_beats, 11);
    check("p0_keep10", rx_keep[10], 4'h3);
    check("p0_no_s_tready", sready_seen, 1'b0);

    // 64-byte payload under random downstream stalls.
    rdy_mode = 1;
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom());
    send_frame(rand_hdr(64), 64, 1'b1);
    check("p64_beats", rx_beats, 27);
    check("p64_keep26", rx_keep[26], 4'h3);

    // Random frames with random stalls and input gaps.
    for (int f = 0; f < 10; f++) begin
      int n;
      n = $urandom_range(1, 80);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom());
      send_frame(rand_hdr(n), n, 1'b1);
    end
    rdy_mode = 0;

    // Declared 10 bytes, 8 sent.
    p0 = len_err_pulses;
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom());
    send_frame(rand_hdr(10), 8, 1'b0);
    check("short_beats", rx_beats, 13);
    check("short_len_err", len_err_pulses, p0 + 1);

    // Reset in the middle of the next frame's header.
    rdy_mode = 2;
    p0 = frames_done;
    @(posedge axis_clk); #1;
    payload_len = 16'd20;
    hdr_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge axis_clk);
      if (hdr_ready) break;
    end
    @(posedge axis_clk); #1;
    hdr_valid = 1'b0;
    repeat (2) @(posedge axis_clk);
    #1;
    check("mid_hdr_valid", m_if.tvalid, 1'b1);
    #2 axis_reset = 1'b1;
    #1;
    check("mid_rst_m_tvalid", m_if.tvalid, 1'b0);
    check("mid_rst_m_tdata", m_if.tdata, 32'h0);
    check("mid_rst_m_tkeep", m_if.tkeep, 4'h0);
    check("mid_rst_m_tlast", m_if.tlast, 1'b0);
    check("mid_rst_hdr_ready", hdr_ready, 1'b0);
    check("mid_rst_s_tready", s_if.tready, 1'b0);
    repeat (2) @(negedge axis_clk);
    axis_reset = 1'b0;
    rdy_mode = 0;
    @(posedge axis_clk); #1;
    check("mid_rel_hdr_ready", hdr_ready, 1'b1);
    repeat (4) @(negedge axis_clk);
    check("mid_no_frame", frames_done, p0);
    check("mid_no_valid", m_if.tvalid, 1'b0);

    check("len_err_total", len_err_pulses, exp_errs);
    check("len_err_width", len_err_hi, len_err_pulses);
    check("model_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
